// File: rtl/sort_stream_checker.sv
// Serial sort-output checker: locks on a sync byte, assembles 32-bit
// words MSB first and counts descending-order violations per frame.
module sort_stream_checker #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned FRAME_WORDS = 8
) (
  input  logic        t_clk,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic        sort_finish,
  output logic        locked,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic        check_done,
  output logic        check_pass,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    RECV,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(FRAME_WORDS - 1);

  state_t      state;
  logic        sf_m;
  logic        sf_s;
  logic [7:0]  sh;
  logic [7:0]  sh_nx;
  logic [31:0] word;
  logic [31:0] word_nx;
  logic [31:0] prev;
  logic        prev_ok;
  logic [4:0]  bit_cnt;
  logic [7:0]  word_cnt;
  logic        viol;

  assign sh_nx   = {sh[6:0], data_in};
  assign word_nx = {word[30:0], data_in};
  assign viol    = prev_ok && (word_nx < prev);

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sf_m       <= 1'b0;
      sf_s       <= 1'b0;
      sh         <= '0;
      word       <= '0;
      prev       <= '0;
      prev_ok    <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      locked     <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      check_done <= 1'b0;
      check_pass <= 1'b0;
      err_count  <= '0;
    end else begin
      sf_m       <= sort_finish;
      sf_s       <= sf_m;
      sh         <= sh_nx;
      word_valid <= 1'b0;
      check_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sf_s) begin
            state     <= HUNT;
            err_count <= '0;
          end
        end
        HUNT: begin
          if (!sf_s) begin
            state <= IDLE;
          end else if (sh_nx == SYNC_BYTE) begin
            state    <= RECV;
            locked   <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= '0;
            word     <= '0;
            prev_ok  <= 1'b0;
          end
        end
        RECV: begin
          // abort wins over a completing word: partial data is dropped
          if (!sf_s) begin
            state  <= IDLE;
            locked <= 1'b0;
          end else begin
            word    <= word_nx;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              word_out   <= word_nx;
              word_valid <= 1'b1;
              prev       <= word_nx;
              prev_ok    <= 1'b1;
              word_cnt   <= word_cnt + 8'd1;
              if (viol && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              if (word_cnt == LAST) begin
                state  <= DONE;
                locked <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          check_done <= 1'b1;
          check_pass <= (err_count == 8'h00);
          state      <= sf_s ? HUNT : IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sort_stream_checker.md
SORT_STREAM_CHECKER -- requirements
Module: sort_stream_checker

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker on serial stream.
REQ-002 Parameter FRAME_WORDS, default 8, 32-bit words per frame (range 1..255).
REQ-003 t_clk  input  1  bit clock, same clock as serial stream; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  1  serial stream from sort datapath serial output, one bit per t_clk, MSB first.
REQ-006 sort_finish  input  1  sort-complete flag from divided-clock domain; asynchronous to this block.
REQ-007 locked  output  1  high while the block is in RECV.
REQ-008 word_valid  output  1  one-cycle pulse, word_out valid.
REQ-009 word_out  output  32  last assembled word.
REQ-010 check_done  output  1  one-cycle pulse at frame end.
REQ-011 check_pass  output  1  frame result, held until next check_done.
REQ-012 err_count  output  8  order violations in current/last frame.

Function
REQ-013 sort_finish SHALL pass through a 2-flop synchronizer on t_clk; only the synchronized value (sf_s) is used.
REQ-014 An 8-bit shift register SHALL shift data_in in at LSB every cycle in all states.
REQ-015 States: IDLE, HUNT, RECV, DONE; reset state IDLE.
REQ-016 IDLE -> HUNT when sf_s=1; err_count cleared to 0 on this transition.
REQ-017 HUNT -> RECV in the cycle after the shift register (including the current bit) equals SYNC_BYTE; bit counter and word counter cleared.
REQ-018 RECV: 32-bit word register shifts data_in in MSB first; bit counter 0..31 wraps to 0 after bit 31.
REQ-019 On bit 31, word_out SHALL update and word_valid pulse in the following cycle (1-cycle latency from last bit).
REQ-020 Each word after the first in a frame SHALL be compared unsigned to the previous word; word < previous increments err_count; equal words are legal.
REQ-021 err_count SHALL saturate at 8'hFF.
REQ-022 After word FRAME_WORDS is assembled: RECV -> DONE; DONE lasts exactly one cycle, pulses check_done, loads check_pass = (err_count==0) including the final comparison.
REQ-023 DONE -> HUNT if sf_s=1, else IDLE.
REQ-024 sf_s falling in HUNT or RECV SHALL abort to IDLE: no check_done, check_pass unchanged, partial word discarded, no word_valid.
REQ-025 SYNC_BYTE patterns appearing inside RECV data SHALL be ignored (no realignment mid-frame).
REQ-026 word_valid and check_done SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, locked 0, word_valid 0, word_out 0, check_done 0, check_pass 0, err_count 0, shift/word registers and counters 0, synchronizer flops 0.
REQ-028 Reset assertion mid-frame SHALL discard the frame with no check_done; after release the block waits in IDLE for sf_s=1.
REQ-029 Reset deassertion is synchronized externally; no output pulses in the first cycle after release.

Verification
REQ-030 Sorted frame: sort_finish=1, stream A5 then words 1,2,3,4,5,6,7,8 -> eight word_valid pulses with those values, check_done pulse, check_pass=1, err_count=0.
REQ-031 Unsorted frame: words 1,2,9,3,4,5,6,7 -> err_count=1, check_pass=0; next frame sorted -> err_count cleared only if via IDLE, else check_pass reflects new count.
REQ-032 Misaligned start: 5 random bits then A5 then frame -> lock exactly after A5, words correct; A5 bytes inside word data do not relock.
REQ-033 Abort: sort_finish drops after word 3 -> no check_done, state IDLE within 3 cycles, check_pass keeps prior value.
REQ-034 Reset mid-frame: rst_n low at word 4 bit 10 -> all outputs 0 same cycle; after release and sort_finish=1, a new full frame checks correctly.
REQ-035 Saturation: FRAME_WORDS=255 descending words FFFFFFFF downward -> err_count=254 at check_done; with forced extra violations err_count stops at FF.
